// File: rtl/lock_pkg.sv
// Shared definitions for the code lock and its transmit-side sender.
package lock_pkg;

    localparam int CODE_W = 8;
    localparam logic [CODE_W-1:0] IDLE_CODE = 8'h00;
    localparam logic [3*CODE_W-1:0] LOCK_SEQ = 24'hAABBCC;

    // Width of the shared hold/gap/timeout down-counter.
    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        WAIT
    } sender_state_t;

endpackage

// File: rtl/lock_sender_timer.sv
// Loadable down-counter; counts to zero and parks there until reloaded.
module lock_sender_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Sends a latched multi-byte unlock sequence to the lock, waits for
// the unlocked status and retries a bounded number of times.
module lock_code_sender #(
    parameter int CODE_LEN = 3,
    parameter int CODE_W = lock_pkg::CODE_W,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES = 1,
    parameter logic [CODE_W-1:0] IDLE_CODE = CODE_W'(lock_pkg::IDLE_CODE),
    parameter int TIMEOUT = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CODE_LEN*CODE_W-1:0]   code_seq,
    input  logic                         unlocked_in,
    output logic [CODE_W-1:0]            code,
    output logic                         code_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic [1:0]                   attempt,
    output lock_pkg::sender_state_t      state_dbg
);

    import lock_pkg::*;

    localparam int SEQ_W = CODE_LEN * CODE_W;
    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    // valid/ready: start is a one-cycle request honoured only in IDLE (no
    // ready back-pressure); done/fail are single-cycle result strobes.
    sender_state_t     state;
    logic [SEQ_W-1:0]  seq_r;
    logic [IDX_W-1:0]  idx;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              can_retry;

    function automatic logic [CODE_W-1:0] pick(input logic [SEQ_W-1:0] s,
                                               input logic [IDX_W-1:0] i);
        return s[(CODE_LEN - 1 - int'(i)) * CODE_W +: CODE_W];
    endfunction

    assign can_retry = (int'(attempt) < MAX_RETRY);
    assign state_dbg = state;

    // Timer reloads on the same edge that enters the next phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!abort) begin
            case (state)
                IDLE: if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYCLES - 1);
                end
                SEND: if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (idx == LAST_IDX)     tmr_val = TMR_W'(TIMEOUT - 1);
                    else if (GAP_CYCLES > 0) tmr_val = TMR_W'(GAP_CYCLES - 1);
                    else                     tmr_val = TMR_W'(HOLD_CYCLES - 1);
                end
                GAP: if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYCLES - 1);
                end
                WAIT: if (!unlocked_in && tmr_zero && can_retry) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYCLES - 1);
                end
                default: ;
            endcase
        end
    end

    lock_sender_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            seq_r      <= '0;
            idx        <= '0;
            attempt    <= '0;
            code       <= IDLE_CODE;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                code       <= IDLE_CODE;
                code_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        seq_r      <= code_seq;
                        attempt    <= '0;
                        idx        <= '0;
                        state      <= SEND;
                        code       <= pick(code_seq, '0);
                        code_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                    SEND: if (tmr_zero) begin
                        if (idx == LAST_IDX) begin
                            state      <= WAIT;
                            code       <= IDLE_CODE;
                            code_valid <= 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            state      <= GAP;
                            code       <= IDLE_CODE;
                            code_valid <= 1'b0;
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            code <= pick(seq_r, idx + IDX_W'(1));
                        end
                    end
                    GAP: if (tmr_zero) begin
                        state      <= SEND;
                        idx        <= idx + IDX_W'(1);
                        code       <= pick(seq_r, idx + IDX_W'(1));
                        code_valid <= 1'b1;
                    end
                    WAIT: begin
                        // Success takes precedence over a timeout in the same cycle.
                        if (unlocked_in) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (tmr_zero) begin
                            if (can_retry) begin
                                attempt    <= attempt + 2'd1;
                                idx        <= '0;
                                state      <= SEND;
                                code       <= pick(seq_r, '0);
                                code_valid <= 1'b1;
                            end else begin
                                fail  <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender with a behavioural lock model on the
// default instance and a second instance built with GAP_CYCLES=0.
module tb_lock_code_sender;

    import lock_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, abort, start2, abort2;
    logic [23:0] code_seq, code_seq2;
    logic        unlocked_in, unl2;
    logic [7:0]  code, code2;
    logic        code_valid, busy, done, fail;
    logic        code_valid2, busy2, done2, fail2;
    logic [1:0]  attempt, attempt2;
    sender_state_t state_dbg, state_dbg2;

    logic        force_en, force_val;
    logic        prev_valid, lock_final;
    logic [7:0]  prev_code;
    logic [23:0] hist;

    logic [7:0]  exp_q[$];
    logic [7:0]  exp;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt, fail_cnt, fail_cyc;

    always #5 clk = ~clk;

    lock_code_sender dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .code_seq(code_seq), .unlocked_in(unlocked_in), .code(code),
        .code_valid(code_valid), .busy(busy), .done(done), .fail(fail),
        .attempt(attempt), .state_dbg(state_dbg)
    );

    lock_code_sender #(.GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .code_seq(code_seq2), .unlocked_in(unl2), .code(code2),
        .code_valid(code_valid2), .busy(busy2), .done(done2), .fail(fail2),
        .attempt(attempt2), .state_dbg(state_dbg2)
    );

    // Lock model: collects distinct bytes, decides one cycle after the last
    // valid byte, and raises unlocked the cycle after that.
    always @(posedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_code  <= 8'h00;
            hist       <= 24'h0;
            lock_final <= 1'b0;
        end else begin
            prev_valid <= code_valid;
            prev_code  <= code;
            if (code_valid && (!prev_valid || code != prev_code))
                hist <= {hist[15:0], code};
            if (code_valid)      lock_final <= 1'b0;
            else if (prev_valid) lock_final <= (hist == LOCK_SEQ);
        end
    end

    assign unlocked_in = force_en ? force_val : lock_final;
    assign unl2 = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; code_seq = 24'h0;
        start2 = 1'b0; abort2 = 1'b0; code_seq2 = 24'h0;
        force_en = 1'b0; force_val = 1'b0;
        tick_n(2);
        check("rst_code", 32'(code), 32'h00);
        check("rst_valid", 32'(code_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_attempt", 32'(attempt), 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Correct sequence against the lock model
        code_seq = 24'hAABBCC; start = 1'b1; tick(); start = 1'b0;
        exp_q = {8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hBB, 8'h00, 8'hCC, 8'hCC};
        for (int c = 1; c <= 8; c++) begin
            exp = exp_q.pop_front();
            check("t1_code", 32'(code), 32'(exp));
            check("t1_valid", 32'(code_valid), (c != 3 && c != 6) ? 1 : 0);
            tick();
        end
        check("t1_wait_state", 32'(state_dbg), 32'(WAIT));
        tick();
        check("t1_done_c10", 32'(done), 0);
        tick();
        check("t1_done_c11", 32'(done), 1);
        check("t1_attempt", 32'(attempt), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_fail", 32'(fail), 0);
        tick();
        check("t1_done_c12", 32'(done), 0);

        // Wrong sequence: three attempts then fail
        code_seq = 24'hAABBCD; start = 1'b1; tick(); start = 1'b0;
        done_cnt = 0; fail_cnt = 0; fail_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 17) check("t2_attempt1", 32'(attempt), 1);
            if (c == 24) check("t2_code_cd", 32'(code), 32'hCD);
            if (c == 33) check("t2_attempt2", 32'(attempt), 2);
            if (done) done_cnt++;
            if (fail) begin
                fail_cnt++;
                fail_cyc = c;
            end
            tick();
        end
        check("t2_fail_cnt", 32'(fail_cnt), 1);
        check("t2_fail_cyc", 32'(fail_cyc), 49);
        check("t2_done_cnt", 32'(done_cnt), 0);
        check("t2_attempt_hold", 32'(attempt), 2);
        check("t2_busy", 32'(busy), 0);

        // unlocked high before WAIT must be ignored
        force_en = 1'b1; force_val = 1'b1;
        code_seq = 24'hAABBCC; start = 1'b1; tick(); start = 1'b0;
        tick_n(8);
        force_val = 1'b0;
        done_cnt = 0;
        for (int c = 9; c <= 16; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("t3_done_c17", 32'(done), 0);
        check("t3_done_cnt", 32'(done_cnt), 0);
        check("t3_retry_state", 32'(state_dbg), 32'(SEND));
        check("t3_attempt", 32'(attempt), 1);
        force_en = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("t3_abort_busy", 32'(busy), 0);
        check("t3_abort_state", 32'(state_dbg), 32'(IDLE));
        check("t3_abort_done", 32'(done), 0);
        check("t3_abort_fail", 32'(fail), 0);
        check("t3_abort_attempt", 32'(attempt), 1);

        // Abort in the gap after byte 1, then restart
        code_seq = 24'hAABBCC; start = 1'b1; tick(); start = 1'b0;
        tick_n(5);
        check("t4_gap_state", 32'(state_dbg), 32'(GAP));
        abort = 1'b1; tick(); abort = 1'b0;
        check("t4_code", 32'(code), 32'h00);
        check("t4_busy", 32'(busy), 0);
        check("t4_valid", 32'(code_valid), 0);
        check("t4_done", 32'(done), 0);
        check("t4_fail", 32'(fail), 0);
        check("t4_state", 32'(state_dbg), 32'(IDLE));
        start = 1'b1; tick(); start = 1'b0;
        check("t4_restart_code", 32'(code), 32'hAA);
        check("t4_restart_valid", 32'(code_valid), 1);
        tick_n(10);
        check("t4_restart_done", 32'(done), 1);
        tick();

        // start while busy is ignored
        code_seq = 24'hAABBCC; start = 1'b1; tick(); start = 1'b0;
        tick();
        code_seq = 24'h112233; start = 1'b1; tick(); start = 1'b0;
        check("t5_gap_code", 32'(code), 32'h00);
        tick();
        check("t5_byte1", 32'(code), 32'hBB);
        tick_n(3);
        check("t5_byte2", 32'(code), 32'hCC);
        tick_n(4);
        check("t5_done", 32'(done), 1);
        tick();

        // Reset during WAIT of the second attempt
        code_seq = 24'hAABBCD; start = 1'b1; tick(); start = 1'b0;
        tick_n(25);
        check("t6_wait_state", 32'(state_dbg), 32'(WAIT));
        check("t6_pre_attempt", 32'(attempt), 1);
        reset = 1'b1; tick();
        check("t6_code", 32'(code), 32'h00);
        check("t6_valid", 32'(code_valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        check("t6_fail", 32'(fail), 0);
        check("t6_attempt", 32'(attempt), 0);
        check("t6_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0; tick();

        // Back-to-back bytes with no gap
        code_seq2 = 24'hAABBCC; start2 = 1'b1; tick(); start2 = 1'b0;
        exp_q = {8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
        for (int c = 1; c <= 6; c++) begin
            exp = exp_q.pop_front();
            check("t7_code", 32'(code2), 32'(exp));
            check("t7_valid", 32'(code_valid2), 1);
            tick();
        end
        check("t7_wait_state", 32'(state_dbg2), 32'(WAIT));
        check("t7_wait_code", 32'(code2), 32'h00);
        check("t7_wait_valid", 32'(code_valid2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_code_sender.md
# lock_code_sender

Transmit-side companion to the code lock. On a start request it latches a multi-byte unlock sequence, drives each byte onto the lock's `code` bus for a programmable hold time with idle gaps between bytes, then watches the lock's `unlocked` output. It reports success or failure and retries a bounded number of times. It sits between the control/test logic and the lock's code input.

## Interface
- `CODE_LEN`, default 3: number of bytes in the sequence.
- `CODE_W`, default 8: width of each code byte.
- `HOLD_CYCLES`, default 2: cycles each byte is driven (≥1).
- `GAP_CYCLES`, default 1: cycles of `IDLE_CODE` between bytes (0 allowed).
- `IDLE_CODE`, default 8'h00: value driven when not sending.
- `TIMEOUT`, default 8: cycles to wait for `unlocked_in` after the last byte (≥1).
- `MAX_RETRY`, default 2: extra attempts after the first.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `abort` in 1: returns the block to IDLE next cycle from any state.
- `code_seq` in CODE_LEN*CODE_W: sequence, latched on accepted `start`. Byte 0 is the MSB slice.
- `unlocked_in` in 1: lock status, sampled only in WAIT.
- `code` out CODE_W: bus to the lock.
- `code_valid` out 1: high while a sequence byte (not idle/gap) is driven.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on success.
- `fail` out 1: one-cycle pulse when retries are exhausted.
- `attempt` out 2: current attempt index (0-based); holds its final value until next start.

## Operation
- Reset values: `code`=IDLE_CODE; `code_valid`, `busy`, `done`, `fail` = 0; `attempt`=0; state IDLE.
- States and transitions:
  - IDLE: on `start`, latch `code_seq`, set `attempt`=0 and go to SEND with byte index 0.
  - SEND: drive byte[idx] with `code_valid`=1 for HOLD_CYCLES cycles. When done, go to GAP if idx<CODE_LEN-1 and GAP_CYCLES>0. If idx<CODE_LEN-1 and GAP_CYCLES=0, go straight to SEND idx+1. If idx=CODE_LEN-1, go to WAIT.
  - GAP: drive IDLE_CODE with `code_valid`=0 for GAP_CYCLES cycles, then go to SEND idx+1.
  - WAIT: drive IDLE_CODE. If `unlocked_in`=1, pulse `done` and go to IDLE. After TIMEOUT cycles without it, retry or fail:
    - if `attempt`<MAX_RETRY, increment `attempt` and go to SEND idx 0;
    - otherwise pulse `fail` and go to IDLE.
- `done` and `fail` are registered and asserted in the cycle the state returns to IDLE. They are never high together.
- `start` while busy: ignored; the latched sequence is unchanged.
- `abort`: highest priority after `reset`. Next cycle: IDLE, `code`=IDLE_CODE, no `done`/`fail` pulse, `attempt` holds.
- Simultaneous `unlocked_in` and timeout expiry in the same cycle: success wins.
- `unlocked_in` high before WAIT is ignored. It is first sampled in the first WAIT cycle.
- Reset mid-operation: all outputs return to reset values in the next cycle.

## Timing
- `start` accepted at cycle 0; byte 0 appears on `code` at cycle 1.
- Byte k starts at cycle 1 + k*(HOLD_CYCLES+GAP_CYCLES).
- WAIT begins one cycle after the last byte's final hold cycle.
- Lock latency: the lock reaches its final state one cycle after seeing the last byte and raises `unlocked` one cycle later. TIMEOUT must be ≥2; default 8 covers this.
- With defaults, the first WAIT cycle is cycle 9. `done` rises at cycle 11 against a correct lock.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `lock_pkg`:
  - state enum `sender_state_t` {IDLE, SEND, GAP, WAIT};
  - `CODE_W` and `IDLE_CODE` constants;
  - default unlock sequence `LOCK_SEQ` = 24'hAABBCC, also usable by lock-side benches.
- One natural sub-module: `lock_sender_timer`, a loadable down-counter shared by the hold, gap and timeout phases. It has load value and load strobe inputs and a `zero` output.
- Remaining logic (FSM, byte index, attempt counter, sequence register) stays in the top level.

## Test plan
- Defaults, `code_seq`=24'hAABBCC, connected to a real lock: `code` shows AA,AA,00,BB,BB,00,CC,CC starting at cycle 1. `done` pulses at cycle 11, `attempt`=0.
- `code_seq`=24'hAABBCD against the lock, MAX_RETRY=2: three full transmissions, each followed by an 8-cycle WAIT. `fail` pulses once, `attempt`=2, `done` never asserted.
- `unlocked_in` forced to 1 during SEND, then to 0 from WAIT onward: no `done`; timeout path taken.
- `abort` asserted during GAP after byte 1: next cycle `code`=00, `busy`=0, no `done`/`fail` pulse. A new `start` then resends from byte 0.
- `start` pulsed again mid-SEND with `code_seq`=24'h112233: it is ignored, and the transmission continues with AA/BB/CC.
- `reset` asserted in WAIT: next cycle every output equals its reset value. GAP_CYCLES=0 run: bytes are back-to-back (AA,AA,BB,BB,CC,CC).
